// File: rtl/cam_pkg.sv
// Shared sizing constants and FSM state encoding for the CAM lookup controller.
package cam_pkg;
    localparam int CAM_DEPTH  = 32;
    localparam int CAM_IDX_W  = 5;
    localparam int CAM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } cam_state_e;
endpackage

// File: rtl/cam_alloc_ptr.sv
// Round-robin victim pointer plus saturating occupancy count for CAM allocation.
module cam_alloc_ptr
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH,
    parameter int IDX_W = CAM_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    output logic [IDX_W-1:0] ptr,
    output logic             full
);
    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (alloc) begin
            ptr <= (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
            if (count != FULL_CNT) begin
                count <= count + 1'b1;
            end
        end
    end

    // Full means every entry holds a key, so the next allocation evicts one.
    assign full = (count == FULL_CNT);
endmodule

// File: rtl/cam_lookup_ctrl.sv
// Single-outstanding CAM lookup controller: search, optionally allocate on miss, respond.
module cam_lookup_ctrl
    import cam_pkg::*;
#(
    parameter int DEPTH  = CAM_DEPTH,
    parameter int IDX_W  = CAM_IDX_W,
    parameter int DATA_W = CAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_key_i,
    input  logic              req_alloc_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_hit_o,
    output logic [IDX_W-1:0]  rsp_index_o,
    output logic              rsp_alloc_o,
    output logic              rsp_evict_o,
    output logic              cam_search_o,
    output logic [DATA_W-1:0] cam_search_data_o,
    output logic              cam_write_o,
    output logic [IDX_W-1:0]  cam_write_index_o,
    output logic [DATA_W-1:0] cam_write_data_o,
    input  logic              cam_search_valid_i,
    input  logic [IDX_W-1:0]  cam_search_index_i,
    output logic [2:0]        dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the response holds valid and all rsp_* fields stable until rsp_ready_i is seen.
    cam_state_e        state;
    logic [DATA_W-1:0] key_q;
    logic              alloc_q;
    logic [IDX_W-1:0]  victim_ptr;
    logic              cam_full;

    cam_alloc_ptr #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_alloc_ptr (
        .clk   (clk),
        .rst   (rst),
        .alloc (state == ST_WRITE),
        .ptr   (victim_ptr),
        .full  (cam_full)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            key_q             <= '0;
            alloc_q           <= 1'b0;
            req_ready_o       <= 1'b0;
            rsp_valid_o       <= 1'b0;
            rsp_hit_o         <= 1'b0;
            rsp_index_o       <= '0;
            rsp_alloc_o       <= 1'b0;
            rsp_evict_o       <= 1'b0;
            cam_search_o      <= 1'b0;
            cam_search_data_o <= '0;
            cam_write_o       <= 1'b0;
            cam_write_index_o <= '0;
            cam_write_data_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        key_q             <= req_key_i;
                        alloc_q           <= req_alloc_i;
                        req_ready_o       <= 1'b0;
                        cam_search_o      <= 1'b1;
                        cam_search_data_o <= req_key_i;
                        state             <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    cam_search_o      <= 1'b0;
                    cam_search_data_o <= '0;
                    state             <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cam_search_valid_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_hit_o   <= 1'b1;
                        rsp_index_o <= cam_search_index_i;
                        state       <= ST_RESP;
                    end else if (alloc_q) begin
                        cam_write_o       <= 1'b1;
                        cam_write_index_o <= victim_ptr;
                        cam_write_data_o  <= key_q;
                        state             <= ST_WRITE;
                    end else begin
                        rsp_valid_o <= 1'b1;
                        rsp_hit_o   <= 1'b0;
                        rsp_index_o <= '0;
                        state       <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    // victim_ptr still names the entry written; it advances on this edge.
                    cam_write_o       <= 1'b0;
                    cam_write_index_o <= '0;
                    cam_write_data_o  <= '0;
                    rsp_valid_o       <= 1'b1;
                    rsp_hit_o         <= 1'b0;
                    rsp_alloc_o       <= 1'b1;
                    rsp_evict_o       <= cam_full;
                    rsp_index_o       <= victim_ptr;
                    state             <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_hit_o   <= 1'b0;
                        rsp_index_o <= '0;
                        rsp_alloc_o <= 1'b0;
                        rsp_evict_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Randomized bench for cam_lookup_ctrl; the bench plays the CAM and keeps a table model of it.
module tb_cam_lookup_ctrl;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_key_i = '0;
    logic        req_alloc_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic        rsp_hit_o;
    logic [4:0]  rsp_index_o;
    logic        rsp_alloc_o;
    logic        rsp_evict_o;
    logic        cam_search_o;
    logic [31:0] cam_search_data_o;
    logic        cam_write_o;
    logic [4:0]  cam_write_index_o;
    logic [31:0] cam_write_data_o;
    logic        cam_search_valid_i = 1'b0;
    logic [4:0]  cam_search_index_i = '0;
    logic [2:0]  dbg_state;

    cam_lookup_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_key_i          (req_key_i),
        .req_alloc_i        (req_alloc_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_hit_o          (rsp_hit_o),
        .rsp_index_o        (rsp_index_o),
        .rsp_alloc_o        (rsp_alloc_o),
        .rsp_evict_o        (rsp_evict_o),
        .cam_search_o       (cam_search_o),
        .cam_search_data_o  (cam_search_data_o),
        .cam_write_o        (cam_write_o),
        .cam_write_index_o  (cam_write_index_o),
        .cam_write_data_o   (cam_write_data_o),
        .cam_search_valid_i (cam_search_valid_i),
        .cam_search_index_i (cam_search_index_i),
        .dbg_state          (dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference CAM: key table, round-robin victim, saturating occupancy.
    logic [31:0] m_keys [DEPTH];
    logic        m_vld  [DEPTH];
    int          m_ptr = 0;
    int          m_cnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int find(input logic [31:0] k);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_keys[i] == k) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    function automatic logic [31:0] new_key();
        logic [31:0] k;
        k = $urandom;
        while (find(k) >= 0) k = $urandom;
        return k;
    endfunction

    function automatic logic [31:0] old_key();
        int i;
        i = $urandom_range(0, DEPTH - 1);
        for (int n = 0; n < DEPTH; n++) begin
            if (m_vld[(i + n) % DEPTH]) return m_keys[(i + n) % DEPTH];
        end
        return new_key();
    endfunction

    // Driver: one full request/response transaction, acting as the CAM meanwhile.
    task automatic do_req(input logic [31:0] key, input logic alloc, input int hold);
        int          hit_idx;
        logic        exp_hit, exp_alloc, exp_evict;
        logic [4:0]  exp_idx;
        int          exp_lat, cyc, n_search, n_write;
        logic        got_rsp, pend, clr;
        logic [8:0]  snap;

        hit_idx   = find(key);
        exp_hit   = (hit_idx >= 0);
        exp_alloc = !exp_hit && alloc;
        exp_idx   = exp_hit ? 5'(hit_idx) : (exp_alloc ? 5'(m_ptr) : 5'd0);
        exp_evict = exp_alloc && (m_cnt == DEPTH);
        exp_lat   = exp_alloc ? 4 : 3;

        @(negedge clk);
        check("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_key_i   = key;
        req_alloc_i = alloc;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_key_i   = $urandom;
        req_alloc_i = $urandom_range(0, 1);

        got_rsp = 1'b0; pend = 1'b0; clr = 1'b0;
        cyc = 0; n_search = 0; n_write = 0; snap = '0;
        while (!got_rsp && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (clr) begin
                cam_search_valid_i = 1'b0;
                cam_search_index_i = '0;
                clr = 1'b0;
            end
            if (pend) begin
                cam_search_valid_i = exp_hit;
                cam_search_index_i = exp_hit ? 5'(hit_idx) : 5'($urandom_range(1, 31));
                pend = 1'b0;
                clr  = 1'b1;
            end
            if (cam_search_o) begin
                n_search++;
                check("search_cycle", 64'(cyc), 1);
                check("search_data", cam_search_data_o, key);
                pend = 1'b1;
            end
            if (cam_write_o) begin
                n_write++;
                check("write_cycle", 64'(cyc), 3);
                check("write_index", cam_write_index_o, exp_idx);
                check("write_data", cam_write_data_o, key);
            end
            if (rsp_valid_o) begin
                got_rsp = 1'b1;
                check("rsp_latency", 64'(cyc), 64'(exp_lat));
                check("rsp_hit", rsp_hit_o, exp_hit);
                check("rsp_index", rsp_index_o, exp_idx);
                check("rsp_alloc", rsp_alloc_o, exp_alloc);
                check("rsp_evict", rsp_evict_o, exp_evict);
                snap = {rsp_valid_o, rsp_hit_o, rsp_alloc_o, rsp_evict_o, rsp_index_o};
            end else begin
                check("rsp_idle_zero", {rsp_hit_o, rsp_alloc_o, rsp_evict_o, rsp_index_o}, 0);
            end
            check("req_ready_busy", req_ready_o, 0);
        end
        if (!got_rsp) check("rsp_timeout", 0, 1);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stable", {rsp_valid_o, rsp_hit_o, rsp_alloc_o, rsp_evict_o, rsp_index_o}, snap);
            check("hold_ready", req_ready_o, 0);
            check("hold_no_search", cam_search_o, 0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        check("post_rsp_zero", {rsp_valid_o, rsp_hit_o, rsp_alloc_o, rsp_evict_o, rsp_index_o}, 0);
        check("post_ready", req_ready_o, 1);
        check("search_count", 64'(n_search), 1);
        check("write_count", 64'(n_write), 64'(exp_alloc));

        if (exp_alloc) begin
            m_keys[m_ptr] = key;
            m_vld[m_ptr]  = 1'b1;
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
        end
    endtask

    initial begin
        logic written;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready_o, 0);
        check("rst_rsp", {rsp_valid_o, rsp_hit_o, rsp_alloc_o, rsp_evict_o, rsp_index_o}, 0);
        check("rst_search", {cam_search_o, cam_search_data_o}, 0);
        check("rst_write", {cam_write_o, cam_write_index_o, cam_write_data_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready_o, 1);

        // Directed: first allocation, re-lookup hit, non-allocating miss, held response
        do_req(32'hDEADBEEF, 1'b1, 0);
        do_req(32'hDEADBEEF, 1'b1, 0);
        do_req(new_key(), 1'b0, 0);
        do_req(new_key(), 1'b0, 5);

        // Fill the remaining entries, then one more allocation wraps and evicts
        for (int i = 0; i < DEPTH; i++) do_req(new_key(), 1'b1, $urandom_range(0, 1));

        // Random mix of hits, allocating and plain misses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) do_req(old_key(), 1'(($urandom_range(0, 1))), $urandom_range(0, 3));
            else do_req(new_key(), 1'(($urandom_range(0, 1))), $urandom_range(0, 3));
        end

        // Reset while the write strobe is up
        @(negedge clk);
        req_valid_i = 1'b1;
        req_key_i   = new_key();
        req_alloc_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        written = 1'b0;
        for (int c = 0; c < 10 && !written; c++) begin
            @(negedge clk);
            if (cam_write_o) written = 1'b1;
        end
        check("write_seen", written, 1);
        rst = 1'b1;
        #1;
        check("rst_drops_write", cam_write_o, 0);
        check("rst_no_rsp", rsp_valid_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid_o, 0);
        end
        do_req(new_key(), 1'b1, 0);
        do_req(new_key(), 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cam_lookup_ctrl.md
CAM_LOOKUP_CTRL -- requirements
Module: cam_lookup_ctrl

Interface
REQ-001 Parameters: DEPTH=32 (CAM entries); IDX_W=5 (index width); DATA_W=32 (key width).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid_i  in  1  upstream lookup request valid.
REQ-006 req_ready_o  out  1  controller can accept a request.
REQ-007 req_key_i  in  DATA_W  lookup key.
REQ-008 req_alloc_i  in  1  allocate an entry for the key on a miss.
REQ-009 rsp_valid_o  out  1  response valid.
REQ-010 rsp_ready_i  in  1  downstream accepts the response.
REQ-011 rsp_hit_o  out  1  key was found in the CAM.
REQ-012 rsp_index_o  out  IDX_W  hit index, or allocated index.
REQ-013 rsp_alloc_o  out  1  a new entry was written.
REQ-014 rsp_evict_o  out  1  the allocation overwrote an occupied entry.
REQ-015 cam_search_o, cam_search_data_o  out  1/DATA_W  CAM search strobe and key.
REQ-016 cam_write_o, cam_write_index_o, cam_write_data_o  out  1/IDX_W/DATA_W  CAM write strobe, index and data.
REQ-017 cam_search_valid_i, cam_search_index_i  in  1/IDX_W  CAM search result, valid in the cycle after cam_search_o.

Function
REQ-018 FSM states: IDLE, SEARCH, WAIT, WRITE, RESP. Exactly one request is in flight at a time.
REQ-019 IDLE: req_ready_o=1. A request is accepted when req_valid_i & req_ready_o; key and alloc flag are registered and the FSM goes to SEARCH.
REQ-020 SEARCH: cam_search_o=1 and cam_search_data_o=registered key for exactly one cycle; next state WAIT.
REQ-021 WAIT, hit (cam_search_valid_i=1): register hit=1 and index=cam_search_index_i; go to RESP.
REQ-022 WAIT, miss with alloc=1: go to WRITE.
REQ-023 WAIT, miss with alloc=0: register hit=0 and index=0; go to RESP.
REQ-024 WRITE: cam_write_o=1 for exactly one cycle, index=victim pointer, data=key; set alloc=1; set evict=(count==DEPTH); advance the pointer; go to RESP.
REQ-025 RESP: rsp_valid_o=1 and all rsp_* outputs stable until rsp_ready_i; on the handshake cycle go to IDLE.
REQ-026 Latency from accept edge T: search strobe in cycle T+1; hit response valid from cycle T+3; allocate response valid from cycle T+4.
REQ-027 Victim pointer: IDX_W bits, starts at 0, increments by 1 per allocation, wraps DEPTH-1 -> 0 (round-robin replacement).
REQ-028 Occupancy count: 0..DEPTH; increments per allocation; saturates at DEPTH.
REQ-029 rsp_evict_o=1 only on allocations made when count==DEPTH.
REQ-030 A hit never allocates, even when req_alloc_i=1.
REQ-031 cam_read_* ports are not driven by this block.
REQ-032 All rsp_* outputs are 0 whenever rsp_valid_o=0.

Reset
REQ-033 On rst: state=IDLE, pointer=0, count=0, and all outputs 0 except req_ready_o, which deasserts during rst and asserts in the first cycle after rst falls.
REQ-034 rst mid-operation (any state) aborts the request with no response; any CAM strobe deasserts immediately.

Structure
REQ-035 Shared package cam_pkg: DEPTH, IDX_W, DATA_W, and the state enum typedef.
REQ-036 Sub-module cam_alloc_ptr holds the pointer and occupancy count; ports: alloc strobe, ptr, full.

Verification
REQ-037 Miss, alloc=1, key 0xDEADBEEF after reset -> write index 0; response hit=0, alloc=1, index=0, evict=0 at T+4.
REQ-038 Re-lookup of 0xDEADBEEF with the CAM returning a hit at index 0 -> hit=1, index=0, alloc=0 at T+3, and no cam_write_o.
REQ-039 33 distinct allocating misses -> indices 0..31, then 0 with evict=1 on the 33rd.
REQ-040 Miss with alloc=0 -> hit=0, alloc=0, index=0; the pointer is unchanged.
REQ-041 Hold rsp_ready_i=0 for 5 cycles -> rsp_* stable, req_ready_o=0, and no new search.
REQ-042 Assert rst during WRITE -> cam_write_o drops at once; no response; pointer=0 after release.
